alu_muldiv_seq: RTL and testbench
=================================

ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; the only legal value is 32 (matches shared ALU).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  request pulse; sampled only when ready to accept (REQ-011).
REQ-005 funct  in  2  00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU, 11 REMU.
REQ-006 a, b  in  32 each  operands: multiplicand/multiplier or dividend/divisor.
REQ-007 busy  out  1  high while iterating.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 result  out  32  selected result, held stable between completions.
REQ-010 alu_op  out  4, alu_in_1 / alu_in_2  out  32 each, alu_out  in  32: ports driving and returning from the shared combinational ALU.

Function
REQ-011 FSM states: IDLE, RUN, DONE. IDLE->RUN and DONE->RUN on start=1; RUN->DONE when the iteration counter reaches 31; DONE->IDLE when start=0.
REQ-012 Operands and funct SHALL be latched on the accepting edge; later input changes SHALL have no effect on the operation in flight.
REQ-013 Latency: start accepted at edge 0; busy=1 during cycles 1..32; done=1 and busy=0 in cycle 33 only; result valid from cycle 33.
REQ-014 start while in RUN SHALL be ignored, with no queueing.
REQ-015 start=1 in the DONE cycle SHALL launch the next operation (back-to-back); done still pulses exactly one cycle.
REQ-016 The 5-bit counter SHALL run 0..31 in RUN, with exactly 32 iterations per operation.
REQ-017 Multiply: 64-bit {hi,lo}, hi=0, lo=b, multiplicand M=a. Each iteration: alu_op=ADD, alu_in_1=hi, alu_in_2 = lo[0] ? M : 0, carry = (alu_out < hi) unsigned, then {hi,lo} <= {carry, alu_out, lo[31:1]}.
REQ-018 Divide (restoring): R=0, Q=a, D=b. Each iteration: {msb,Rs} = {R,Q[31]}; alu_op=SUB, alu_in_1=Rs, alu_in_2=D; take = msb | !(Rs < D); R <= take ? alu_out : Rs; Q <= {Q[30:0], take}.
REQ-019 Results: MUL = lo, MULHU = hi, DIVU = Q, REMU = R, all modulo 2^32.
REQ-020 Divide by zero SHALL produce DIVU = 0xFFFFFFFF and REMU = a through the normal 32-cycle path, with no special case and no exception.
REQ-021 Outside RUN, the ALU drive SHALL be alu_op=ADD, alu_in_1=0, alu_in_2=0.
REQ-022 result SHALL update only on entry to DONE.

Reset
REQ-023 When rst=1 at an edge: state=IDLE, counter=0, busy=0, done=0, result=0, and internal hi/lo/R/Q/M/D = 0.
REQ-024 rst SHALL take priority over start.
REQ-025 rst mid-operation SHALL abort the operation; no done pulse for the aborted operation; the next start after rst deasserts SHALL be accepted normally.

Structure
REQ-026 Shared package alu_pkg SHALL hold the 4-bit ALU op enum (ADD 4'b0000, SUB 4'b1000, plus the existing ALU codes) and the 2-bit funct enum; this block and the ALU import it.
REQ-027 There SHALL be a single module with no sub-module; the ALU is instantiated outside and connected via the alu_* ports.

Verification
REQ-028 MUL a=7, b=6 -> done in cycle 33, result=42; MULHU with the same operands -> result=0.
REQ-029 MULHU a=b=0xFFFFFFFF -> result=0xFFFFFFFE; MUL with the same operands -> result=0x00000001.
REQ-030 DIVU a=100, b=7 -> result=14; REMU with the same operands -> result=2.
REQ-031 DIVU a=0x1234, b=0 -> result=0xFFFFFFFF; REMU with the same operands -> result=0x1234.
REQ-032 Start MUL 3*5, pulse start with other operands at cycle 10 -> ignored, result=15 at cycle 33; start held at cycle 33 -> second operation done at cycle 66.
REQ-033 Start DIVU, assert rst at cycle 12 -> busy=0, done=0, result=0 next cycle; no done afterwards until a new start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU package: operation codes driven to the shared combinational ALU
// and the multiply/divide function selector.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    FN_MUL   = 2'b00,
    FN_MULHU = 2'b01,
    FN_DIVU  = 2'b10,
    FN_REMU  = 2'b11
  } funct_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle of the sequential multiply/divide unit.
interface alu_muldiv_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  funct_e           funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, funct, a, b, input busy, done, result);
  modport slave  (input start, funct, a, b, output busy, done, result);
endinterface

// File: rtl/alu_muldiv_seq.sv
// 32-iteration shift-add multiplier / restoring divider that borrows an
// external shared ALU for its add and subtract steps.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  alu_muldiv_seq_if.slave  bus,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_in_1,
  output logic [WIDTH-1:0] alu_in_2,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [4:0]       r_cnt;
  funct_e           r_funct;
  logic [WIDTH-1:0] r_hi, r_lo, r_m;
  logic [WIDTH-1:0] r_r, r_q, r_d;
  logic [WIDTH-1:0] r_result;

  logic             w_is_div;
  logic             w_accept;
  logic [WIDTH-1:0] w_rs;
  logic             w_take;
  logic             w_carry;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt, w_r_nxt, w_q_nxt;
  logic [WIDTH-1:0] w_res;

  assign w_is_div = (r_funct == FN_DIVU) || (r_funct == FN_REMU);
  assign w_accept = bus.start && (r_state != S_RUN);

  // Divide step: the remainder shifts left taking the next dividend bit;
  // its old MSB is the 33rd bit that guarantees the subtraction fits.
  assign w_rs     = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
  assign w_take   = r_r[WIDTH-1] | !(w_rs < r_d);
  assign w_r_nxt  = w_take ? alu_out : w_rs;
  assign w_q_nxt  = {r_q[WIDTH-2:0], w_take};

  assign w_carry  = alu_out < r_hi;
  assign w_hi_nxt = {w_carry, alu_out[WIDTH-1:1]};
  assign w_lo_nxt = {alu_out[0], r_lo[WIDTH-1:1]};

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    alu_op   = ALU_ADD;
    alu_in_1 = '0;
    alu_in_2 = '0;
    if (r_state == S_RUN) begin
      if (w_is_div) begin
        alu_op   = ALU_SUB;
        alu_in_1 = w_rs;
        alu_in_2 = r_d;
      end else begin
        alu_in_1 = r_hi;
        alu_in_2 = r_lo[0] ? r_m : '0;
      end
    end
  end

  always_comb begin
    unique case (r_funct)
      FN_MUL:   w_res = w_lo_nxt;
      FN_MULHU: w_res = w_hi_nxt;
      FN_DIVU:  w_res = w_q_nxt;
      default:  w_res = w_r_nxt;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are cleared too, so an aborted operation leaves no residue.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct  <= FN_MUL;
      r_hi     <= '0;
      r_lo     <= '0;
      r_m      <= '0;
      r_r      <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_state  <= S_RUN;
      r_cnt    <= '0;
      r_funct  <= bus.funct;
      r_hi     <= '0;
      r_lo     <= bus.b;
      r_m      <= bus.a;
      r_r      <= '0;
      r_q      <= bus.a;
      r_d      <= bus.b;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_is_div) begin
            r_r <= w_r_nxt;
            r_q <= w_q_nxt;
          end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state  <= S_DONE;
            r_result <= w_res;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized and directed bench for alu_muldiv_seq against a plain-arithmetic
// reference, with a behavioural shared ALU attached to the alu_* ports.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_1, alu_in_2, alu_out;

  int n_cmp = 0;
  int n_err = 0;

  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_op   (alu_op),
    .alu_in_1 (alu_in_1),
    .alu_in_2 (alu_in_2),
    .alu_out  (alu_out)
  );

  // Shared ALU stand-in: only ADD and SUB are meaningful for this block.
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_out = alu_in_1 + alu_in_2;
      ALU_SUB: alu_out = alu_in_1 - alu_in_2;
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input funct_e f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (f)
      FN_MUL:   return p[31:0];
      FN_MULHU: return p[63:32];
      FN_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  // One complete operation from an idle unit; inputs are scrambled right
  // after acceptance so a late-latching design would compute the wrong value.
  task automatic run_op(input string tag, input funct_e f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          lat;
    bit          busy_ok;
    exp = model(f, a, b);
    bus.start = 1'b1;
    bus.funct = f;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.funct = funct_e'($urandom_range(0, 3));
    check({tag, "/alu_op"}, 32'(alu_op), (f == FN_DIVU || f == FN_REMU) ? 32'(ALU_SUB) : 32'(ALU_ADD));
    lat     = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (bus.done) begin
        lat = c;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      tick();
    end
    check({tag, "/latency"}, 32'(lat), 32'd33);
    check({tag, "/busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, "/busy_done"}, 32'(bus.busy), 32'd0);
    check({tag, "/result"}, bus.result, exp);
    tick();
    check({tag, "/done_1cyc"}, 32'(bus.done), 32'd0);
    check({tag, "/held"}, bus.result, exp);
  endtask

  initial begin
    int cyc;
    int n_done;
    funct_e rf;
    logic [31:0] ra, rb;

    rst       = 1'b1;
    bus.start = 1'b1;
    bus.funct = FN_MUL;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    tick();
    tick();
    check("reset/busy", 32'(bus.busy), 32'd0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/result", bus.result, 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    check("idle/alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("idle/alu_in_1", alu_in_1, 32'd0);
    check("idle/alu_in_2", alu_in_2, 32'd0);

    run_op("mul_7x6",    FN_MUL,   32'd7, 32'd6);
    run_op("mulhu_7x6",  FN_MULHU, 32'd7, 32'd6);
    run_op("mulhu_ones", FN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul_ones",   FN_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu_100_7", FN_DIVU,  32'd100, 32'd7);
    run_op("remu_100_7", FN_REMU,  32'd100, 32'd7);
    run_op("divu_by0",   FN_DIVU,  32'h1234, 32'd0);
    run_op("remu_by0",   FN_REMU,  32'h1234, 32'd0);

    for (int i = 0; i < 12; i++) begin
      rf = funct_e'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), rf, ra, rb);
    end

    // Start ignored mid-run, then back-to-back launch from the DONE cycle.
    bus.start = 1'b1;
    bus.funct = FN_MUL;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    tick();
    cyc = 1;
    while (cyc <= 40 && !bus.done) begin
      bus.start = (cyc == 10);
      if (cyc == 10) begin
        bus.a = 32'd9;
        bus.b = 32'd9;
      end
      tick();
      cyc++;
    end
    check("b2b/first_latency", 32'(cyc), 32'd33);
    check("b2b/first_result", bus.result, 32'd15);
    bus.start = 1'b1;
    bus.funct = FN_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    tick();
    cyc++;
    bus.start = 1'b0;
    check("b2b/done_1cyc", 32'(bus.done), 32'd0);
    check("b2b/busy_again", 32'(bus.busy), 32'd1);
    while (cyc <= 80 && !bus.done) begin
      tick();
      cyc++;
    end
    check("b2b/second_latency", 32'(cyc), 32'd66);
    check("b2b/second_result", bus.result, 32'd14);
    tick();

    // Reset in the middle of a divide aborts it without a done pulse.
    bus.start = 1'b1;
    bus.funct = FN_DIVU;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 12; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort/busy", 32'(bus.busy), 32'd0);
    check("abort/done", 32'(bus.done), 32'd0);
    check("abort/result", bus.result, 32'd0);
    n_done = 0;
    for (int c = 0; c < 50; c++) begin
      if (bus.done) n_done++;
      tick();
    end
    check("abort/no_done", 32'(n_done), 32'd0);
    run_op("after_abort", FN_REMU, 32'd1000, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
